// File: rtl/uart8_rx.sv
// uart8_rx: 8N1/8N2 UART receiver. 16x DDS oversampling (shared programming word
// with uart8_tx), 2-flop input synchroniser, 3-sample majority vote at mid-cell,
// stop-bit check, one-clk rxvalid strobe per frame.
module uart8_rx #(
  parameter int unsigned STOPBITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] baud_rate16,
  input  logic        rxd,
  output logic [7:0]  rxdata,
  output logic        rxvalid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned LAST_SLOT = 8 + STOPBITS;
  // WAIT_IDLE needs the line high for this many clks beyond the first high sample,
  // long enough to flush the synchroniser's reset value of 1.
  localparam int unsigned IDLE_CLKS = 3;

  generate
    if (STOPBITS != 1 && STOPBITS != 2) begin : g_bad_stopbits
      $error("uart8_rx: STOPBITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECV
  } state_t;

  logic        rxd_m_q;
  logic        rxd_s_q;
  logic [23:0] acc_q;
  logic        tick_q;
  logic [24:0] dds_d;
  logic [7:0]  cntr_q;
  state_t      state_q;
  logic        s6_q;
  logic        s7_q;
  logic [7:0]  shift_q;
  logic        stop_ok_q;
  logic [7:0]  rxdata_q;
  logic        rxvalid_q;
  logic        frame_err_q;
  logic        busy_q;

  logic [3:0]  slot;
  logic [3:0]  offset;
  logic        vote;
  logic        frame_ok;

  assign slot     = cntr_q[7:4];
  assign offset   = cntr_q[3:0];
  assign vote     = (s6_q & s7_q) | (s6_q & rxd_s_q) | (s7_q & rxd_s_q);
  assign frame_ok = stop_ok_q & vote;
  assign dds_d    = {1'b0, acc_q} + {1'b0, baud_rate16};

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      rxd_m_q <= rxd;
      rxd_s_q <= rxd_m_q;
    end
  end

  // DDS baud generator: carry-out of the accumulator is the 16x tick; parked at 0 while idle.
  always_ff @(posedge clk) begin
    if (rst || !busy_q) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= dds_d[23:0];
      tick_q <= dds_d[24];
    end
  end

  // Receive FSM: start qualification, bit voting, data shift, stop check and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      cntr_q      <= '0;
      s6_q        <= 1'b1;
      s7_q        <= 1'b1;
      shift_q     <= '0;
      stop_ok_q   <= 1'b1;
      rxdata_q    <= '0;
      rxvalid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rxvalid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        WAIT_IDLE: begin
          busy_q <= 1'b0;
          if (rxd_s_q) begin
            if (cntr_q == 8'(IDLE_CLKS)) begin
              state_q <= IDLE;
              cntr_q  <= '0;
            end else begin
              cntr_q <= cntr_q + 8'd1;
            end
          end else begin
            cntr_q <= '0;
          end
        end
        IDLE: begin
          busy_q <= 1'b0;
          if (!rxd_s_q) begin
            state_q   <= RECV;
            busy_q    <= 1'b1;
            cntr_q    <= '0;
            stop_ok_q <= 1'b1;
          end
        end
        RECV: begin
          if (tick_q) begin
            cntr_q <= cntr_q + 8'd1;
            if (offset == 4'd6) s6_q <= rxd_s_q;
            if (offset == 4'd7) s7_q <= rxd_s_q;
            if (offset == 4'd8) begin
              if (slot == 4'd0) begin
                if (vote) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end else if (slot <= 4'd8) begin
                shift_q <= {vote, shift_q[7:1]};
              end else if (slot == 4'(LAST_SLOT)) begin
                rxdata_q    <= shift_q;
                rxvalid_q   <= 1'b1;
                frame_err_q <= !frame_ok;
                busy_q      <= 1'b0;
                cntr_q      <= '0;
                state_q     <= frame_ok ? IDLE : WAIT_IDLE;
              end else begin
                stop_ok_q <= frame_ok;
              end
            end
          end
        end
        default: begin
          state_q <= WAIT_IDLE;
          cntr_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rxdata    = rxdata_q;
  assign rxvalid   = rxvalid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart8_rx.sv
// tb_uart8_rx: directed bench for uart8_rx, one instance per STOPBITS setting.
module tb_uart8_rx;

  localparam logic [23:0] RATE_115K = 24'h04B7F6;
  localparam logic [23:0] RATE_FAST = 24'h200000;  // one tick every 8 clks exactly
  localparam int unsigned BIT_115K  = 868;
  localparam int unsigned BIT_FAST  = 128;
  localparam int unsigned BIT_PLUS3 = 124;         // sender 3% fast
  localparam int unsigned BIT_MIN3  = 132;         // sender 3% slow

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] baud = RATE_115K;
  logic        rxd1 = 1'b1;
  logic        rxd2 = 1'b1;
  logic [7:0]  rxdata1, rxdata2;
  logic        rxvalid1, rxvalid2, frame_err1, frame_err2, busy1, busy2;

  always #5 clk = ~clk;

  uart8_rx #(.STOPBITS(1)) dut1 (
    .clk(clk), .rst(rst), .baud_rate16(baud), .rxd(rxd1),
    .rxdata(rxdata1), .rxvalid(rxvalid1), .frame_err(frame_err1), .busy(busy1)
  );

  uart8_rx #(.STOPBITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_rate16(baud), .rxd(rxd2),
    .rxdata(rxdata2), .rxvalid(rxvalid2), .frame_err(frame_err2), .busy(busy2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Output monitor: logs each strobe and counts strobe-protocol violations.
  int         n_valid1 = 0;
  int         n_valid2 = 0;
  int         n_protocol = 0;
  logic [8:0] log1[$];
  logic [8:0] log2[$];
  logic       prev_valid1 = 1'b0, prev_valid2 = 1'b0;
  logic [7:0] prev_data1 = 8'h00, prev_data2 = 8'h00;
  logic       busy_at_valid1 = 1'b1;
  time        t_valid1 = 0, t_valid2 = 0, t_start = 0;

  always @(negedge clk) begin
    if (rxvalid1) begin
      n_valid1++;
      log1.push_back({frame_err1, rxdata1});
      t_valid1 = $time;
      busy_at_valid1 = busy1;
    end
    if (rxvalid2) begin
      n_valid2++;
      log2.push_back({frame_err2, rxdata2});
      t_valid2 = $time;
    end
    if (!rst && ((rxvalid1 && prev_valid1) || (frame_err1 && !rxvalid1) ||
                 (rxdata1 != prev_data1 && !rxvalid1))) n_protocol++;
    if (!rst && ((rxvalid2 && prev_valid2) || (frame_err2 && !rxvalid2) ||
                 (rxdata2 != prev_data2 && !rxvalid2))) n_protocol++;
    prev_valid1 = rxvalid1;
    prev_data1  = rxdata1;
    prev_valid2 = rxvalid2;
    prev_data2  = rxdata2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits n negedges, then steps 1 unit so the monitor has already sampled.
  task automatic clks(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit line2, input logic v);
    if (line2) rxd2 = v;
    else       rxd1 = v;
  endtask

  // Sends start + 8 data bits LSB first + nstop stop bits; leaves the line at the last stop value.
  task automatic send(input bit line2, input logic [7:0] data, input int unsigned bit_clks,
                      input logic stop1, input logic stop2, input int unsigned nstop);
    t_start = $time;
    drive(line2, 1'b0);
    clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      drive(line2, data[i]);
      clks(bit_clks);
    end
    drive(line2, stop1);
    clks(bit_clks);
    if (nstop == 2) begin
      drive(line2, stop2);
      clks(bit_clks);
    end
  endtask

  logic [7:0] b96 = 8'h96;

  initial begin
    clks(5);
    rst = 1'b0;
    clks(1);
    chk("reset_rxdata",   32'(rxdata1), 32'h00);
    chk("reset_rxvalid",  32'(rxvalid1), 32'h0);
    chk("reset_frame_err", 32'(frame_err1), 32'h0);
    chk("reset_busy",     32'(busy1), 32'h0);
    chk("reset_busy2",    32'(busy2), 32'h0);
    clks(10);

    // 0xA5 at 115200 baud from 100 MHz
    send(1'b0, 8'hA5, BIT_115K, 1'b1, 1'b1, 1);
    clks(20);
    chk("a5_count", 32'(n_valid1), 32'd1);
    chk("a5_frame", 32'(log1[0]), 32'h0A5);
    chk("a5_busy_at_valid", 32'(busy_at_valid1), 32'h0);
    chk("a5_busy_after", 32'(busy1), 32'h0);

    baud = RATE_FAST;
    clks(50);

    // 24-clk (3-tick) low glitch: false start, no strobe
    rxd1 = 1'b0;
    clks(20);
    chk("glitch_busy_high", 32'(busy1), 32'h1);
    clks(4);
    rxd1 = 1'b1;
    clks(100);
    chk("glitch_busy_low", 32'(busy1), 32'h0);
    chk("glitch_no_valid", 32'(n_valid1), 32'd1);

    // 0x3C after the false start; strobe 1228 clks after start edge (driven 1 unit past a negedge)
    send(1'b0, 8'h3C, BIT_FAST, 1'b1, 1'b1, 1);
    clks(20);
    chk("3c_count", 32'(n_valid1), 32'd2);
    chk("3c_frame", 32'(log1[1]), 32'h03C);
    chk("3c_latency", 32'(t_valid1 - t_start), 32'd12279);

    // 0x3C with the stop bit held low for two bit times
    send(1'b0, 8'h3C, BIT_FAST, 1'b0, 1'b0, 2);
    clks(5);
    chk("ferr_count", 32'(n_valid1), 32'd3);
    chk("ferr_frame", 32'(log1[2]), 32'h13C);
    chk("ferr_busy", 32'(busy1), 32'h0);
    clks(200);
    chk("low_line_busy", 32'(busy1), 32'h0);
    chk("low_line_count", 32'(n_valid1), 32'd3);
    rxd1 = 1'b1;
    clks(30);
    send(1'b0, 8'h42, BIT_FAST, 1'b1, 1'b1, 1);
    clks(20);
    chk("42_count", 32'(n_valid1), 32'd4);
    chk("42_frame", 32'(log1[3]), 32'h042);

    // back-to-back frames, sender 3% fast then 3% slow
    send(1'b0, 8'h00, BIT_PLUS3, 1'b1, 1'b1, 1);
    send(1'b0, 8'hFF, BIT_PLUS3, 1'b1, 1'b1, 1);
    send(1'b0, 8'h55, BIT_PLUS3, 1'b1, 1'b1, 1);
    clks(20);
    chk("fast_count", 32'(n_valid1), 32'd7);
    chk("fast_00", 32'(log1[4]), 32'h000);
    chk("fast_ff", 32'(log1[5]), 32'h0FF);
    chk("fast_55", 32'(log1[6]), 32'h055);
    send(1'b0, 8'h00, BIT_MIN3, 1'b1, 1'b1, 1);
    send(1'b0, 8'hFF, BIT_MIN3, 1'b1, 1'b1, 1);
    send(1'b0, 8'h55, BIT_MIN3, 1'b1, 1'b1, 1);
    clks(20);
    chk("slow_count", 32'(n_valid1), 32'd10);
    chk("slow_00", 32'(log1[7]), 32'h000);
    chk("slow_ff", 32'(log1[8]), 32'h0FF);
    chk("slow_55", 32'(log1[9]), 32'h055);

    // reset during data bit 4 of 0x96, released while bit 5 holds the line low
    rxd1 = 1'b0;
    clks(BIT_FAST);
    for (int i = 0; i < 4; i++) begin
      rxd1 = b96[i];
      clks(BIT_FAST);
    end
    rxd1 = b96[4];
    clks(60);
    rst = 1'b1;
    clks(68);
    rxd1 = b96[5];
    clks(30);
    rst = 1'b0;
    clks(3);
    chk("rst_rxdata", 32'(rxdata1), 32'h00);
    chk("rst_rxvalid", 32'(rxvalid1), 32'h0);
    chk("rst_frame_err", 32'(frame_err1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    clks(95);
    rxd1 = b96[6];
    clks(BIT_FAST);
    chk("rst_low_busy", 32'(busy1), 32'h0);
    rxd1 = b96[7];
    clks(BIT_FAST);
    rxd1 = 1'b1;
    clks(BIT_FAST + 100);
    chk("rst_no_valid", 32'(n_valid1), 32'd10);
    send(1'b0, 8'h81, BIT_FAST, 1'b1, 1'b1, 1);
    clks(20);
    chk("81_count", 32'(n_valid1), 32'd11);
    chk("81_frame", 32'(log1[10]), 32'h081);

    // two stop bits: second stop low, then both high with exact strobe timing
    send(1'b1, 8'hC3, BIT_FAST, 1'b1, 1'b0, 2);
    clks(5);
    chk("sb2_err_count", 32'(n_valid2), 32'd1);
    chk("sb2_err_frame", 32'(log2[0]), 32'h1C3);
    rxd2 = 1'b1;
    clks(50);
    send(1'b1, 8'hC3, BIT_FAST, 1'b1, 1'b1, 2);
    clks(20);
    chk("sb2_ok_count", 32'(n_valid2), 32'd2);
    chk("sb2_ok_frame", 32'(log2[1]), 32'h0C3);
    chk("sb2_latency", 32'(t_valid2 - t_start), 32'd13559);
    chk("sb1_quiet", 32'(n_valid1), 32'd11);

    chk("strobe_protocol", 32'(n_protocol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
